// File: rtl/radar_pulse_sched.sv
// Radar pulse scheduler: latches a pulse configuration and drives the transmit gate and per-pulse DDS word.
// Define RADAR_SCHED_LFSR_HOP_EN to replace the bit-reversed hop order with an LFSR-driven one.
module radar_pulse_sched #(
  parameter int          CNT_W    = 26,
  parameter int          FW_W     = 32,
  parameter int          N_STEP   = 8,
  parameter int          STEP_W   = $clog2(N_STEP),
  parameter int          GATE_DLY = 5,
  parameter logic [31:0] FW_SCALE = 32'd8589934,
  parameter int unsigned PW_SCALE = 100
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_load,
  input  logic [3:0]        mode_sel,
  input  logic [10:0]       t_width,
  input  logic [6:0]        duty,
  input  logic [8:0]        f_base,
  output logic [FW_W-1:0]   f_word,
  output logic [FW_W-1:0]   fw_cur,
  output logic              gate,
  output logic              gate_dly,
  output logic              pulse_start,
  output logic [STEP_W-1:0] step_idx,
  output logic              cfg_err
);

  // state | meaning
  // IDLE  | no valid configuration; outputs quiet
  // CALC  | one cycle deriving f_word, PW, PRI and cfg_err
  // ON    | gate currently driven high
  // OFF   | gate currently low, waiting for the period to wrap
  typedef enum logic [1:0] {IDLE, CALC, ON, OFF} state_t;

  localparam logic [STEP_W:0] ONE = 1;

  state_t            state;
  logic [3:0]        mode_q;
  logic [10:0]       tw_q;
  logic [6:0]        duty_q;
  logic [8:0]        fb_q;
  logic [CNT_W-1:0]  pw, pri, cnt;
  logic              cont_q, started;

  logic [CNT_W-1:0]  pw_c, pri_c;
  logic              cfg_bad, on_now, last;
  logic [STEP_W-1:0] rev_idx;
  logic [STEP_W:0]   mult;
  logic [FW_W-1:0]   fw_mul;

`ifdef RADAR_SCHED_LFSR_HOP_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
`endif

  assign pw_c    = CNT_W'(PW_SCALE * tw_q);
  assign pri_c   = CNT_W'(pw_c * duty_q);
  assign cfg_bad = (tw_q == '0) | (duty_q == '0) | !$onehot(mode_q);
  assign on_now  = cont_q | (cnt < pw);
  assign last    = (cnt == pri - CNT_W'(1));

  always_comb begin
    rev_idx = '0;
    for (int i = 0; i < STEP_W; i++) rev_idx[i] = step_idx[STEP_W-1-i];
  end

  always_comb begin
    mult = ONE;
    if (mode_q[2]) mult = {1'b0, step_idx} + ONE;
`ifdef RADAR_SCHED_LFSR_HOP_EN
    else if (mode_q[3]) mult = {1'b0, lfsr[STEP_W-1:0]} + ONE;
`else
    else if (mode_q[3]) mult = {1'b0, rev_idx} + ONE;
`endif
  end

  assign fw_mul = f_word * FW_W'(mult);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      mode_q      <= '0;
      tw_q        <= '0;
      duty_q      <= '0;
      fb_q        <= '0;
      pw          <= '0;
      pri         <= '0;
      cnt         <= '0;
      cont_q      <= 1'b0;
      started     <= 1'b0;
      f_word      <= '0;
      fw_cur      <= '0;
      gate        <= 1'b0;
      pulse_start <= 1'b0;
      step_idx    <= '0;
      cfg_err     <= 1'b0;
`ifdef RADAR_SCHED_LFSR_HOP_EN
      lfsr        <= '0;
`endif
    end else if (cfg_load) begin
      state       <= CALC;
      mode_q      <= mode_sel;
      tw_q        <= t_width;
      duty_q      <= duty;
      fb_q        <= f_base;
      cnt         <= '0;
      step_idx    <= '0;
      started     <= 1'b0;
      gate        <= 1'b0;
      fw_cur      <= '0;
      pulse_start <= 1'b0;
`ifdef RADAR_SCHED_LFSR_HOP_EN
      lfsr        <= 16'hACE1;
`endif
    end else begin
      case (state)
        IDLE: begin
          gate        <= 1'b0;
          fw_cur      <= '0;
          pulse_start <= 1'b0;
        end
        CALC: begin
          f_word  <= FW_W'(FW_SCALE * fb_q);
          pw      <= pw_c;
          pri     <= pri_c;
          cont_q  <= mode_q[0] | (duty_q == 7'd1);
          cfg_err <= cfg_bad;
          state   <= cfg_bad ? IDLE : ON;
        end
        default: begin
          gate        <= on_now;
          fw_cur      <= on_now ? fw_mul : '0;
          // Continuous transmission announces itself only once.
          pulse_start <= on_now && (cnt == '0) && !(cont_q && started);
          if (on_now && (cnt == '0)) started <= 1'b1;
          cnt         <= last ? '0 : cnt + CNT_W'(1);
          if (last) begin
            if (mode_q[2] | mode_q[3]) step_idx <= step_idx + STEP_W'(1);
`ifdef RADAR_SCHED_LFSR_HOP_EN
            lfsr <= {lfsr[14:0], lfsr_fb};
`endif
          end
          state <= on_now ? ON : OFF;
        end
      endcase
    end
  end

  generate
    if (GATE_DLY == 0) begin : g_nodly
      assign gate_dly = gate;
    end else begin : g_dly
      logic [GATE_DLY-1:0] dly_sr;
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) dly_sr <= '0;
        else            dly_sr <= (dly_sr << 1) | GATE_DLY'(gate);
      end
      assign gate_dly = dly_sr[GATE_DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_radar_pulse_sched.sv
// Bench for radar_pulse_sched: directed and randomized configurations against an arithmetic model.
module tb_radar_pulse_sched;

  logic        sys_clk, sys_rst_n, cfg_load;
  logic [3:0]  mode_sel;
  logic [10:0] t_width;
  logic [6:0]  duty;
  logic [8:0]  f_base;
  logic [31:0] f_word, fw_cur;
  logic        gate, gate_dly, pulse_start, cfg_err;
  logic [2:0]  step_idx;

  radar_pulse_sched dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_load(cfg_load),
    .mode_sel(mode_sel), .t_width(t_width), .duty(duty), .f_base(f_base),
    .f_word(f_word), .fw_cur(fw_cur), .gate(gate), .gate_dly(gate_dly),
    .pulse_start(pulse_start), .step_idx(step_idx), .cfg_err(cfg_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: configuration and cycles elapsed since the load edge.
  bit              m_valid;
  int              m_e;
  logic [3:0]      m_mode;
  int              m_tw, m_duty, m_fb;
  longint unsigned exp_fword;
  bit              exp_err;
  logic [4:0]      hist;
  int              hop_tab[8] = '{1, 5, 3, 7, 2, 6, 4, 8};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outputs(input bit eg, input bit eps, input longint unsigned efw,
                               input int estep, input bit egd);
    chk("gate",        64'(gate),        64'(eg));
    chk("pulse_start", 64'(pulse_start), 64'(eps));
    chk("fw_cur",      64'(fw_cur),      efw);
    chk("step_idx",    64'(step_idx),    64'(estep));
    chk("gate_dly",    64'(gate_dly),    64'(egd));
    chk("f_word",      64'(f_word),      exp_fword);
    chk("cfg_err",     64'(cfg_err),     64'(exp_err));
  endtask

  task automatic model_reset();
    m_valid   = 0;
    m_e       = 0;
    exp_fword = 0;
    exp_err   = 0;
    hist      = '0;
  endtask

  task automatic cycle();
    bit ld, eg, eps, egd, cont;
    longint unsigned efw;
    int estep, k, pw, pri, cidx, p, mult;
    ld = (cfg_load === 1'b1) && (sys_rst_n === 1'b1);
    @(posedge sys_clk);
    #1;
    if (!sys_rst_n) model_reset();
    else if (ld) begin
      m_valid = 1; m_e = 0; m_mode = mode_sel;
      m_tw = int'(t_width); m_duty = int'(duty); m_fb = int'(f_base);
    end else if (m_valid) m_e++;
    if (m_valid && m_e == 1) begin
      exp_fword = (64'd8589934 * longint'(m_fb)) & 64'hFFFF_FFFF;
      exp_err   = (m_tw == 0) || (m_duty == 0) || ($countones(m_mode) != 1);
    end
    eg = 0; eps = 0; efw = 0; estep = 0;
    if (m_valid && m_e >= 2 && !exp_err) begin
      k    = m_e - 2;
      pw   = 100 * m_tw;
      pri  = pw * m_duty;
      cont = (m_mode == 4'b0001) || (m_duty == 1);
      cidx = k % pri;
      p    = k / pri;
      eg   = cont || (cidx < pw);
      if (m_mode == 4'b0100)      mult = p % 8 + 1;
      else if (m_mode == 4'b1000) mult = hop_tab[p % 8];
      else                        mult = 1;
      efw  = eg ? ((exp_fword * longint'(mult)) & 64'hFFFF_FFFF) : 0;
      eps  = eg && (cidx == 0) && (!cont || k == 0);
      if (m_mode == 4'b0100 || m_mode == 4'b1000) estep = ((k + 1) / pri) % 8;
    end
    egd  = hist[4];
    hist = {hist[3:0], eg};
    check_outputs(eg, eps, efw, estep, egd);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_load = 1'b0;
      mode_sel = 4'($urandom);
      t_width  = 11'($urandom);
      duty     = 7'($urandom);
      f_base   = 9'($urandom);
      cycle();
    end
  endtask

  task automatic load(input logic [3:0] m, input int tw, input int d, input int fb);
    mode_sel = m;
    t_width  = 11'(tw);
    duty     = 7'(d);
    f_base   = 9'(fb);
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
  endtask

  initial begin
    int sel;
    logic [3:0] rm;
    cfg_load = 0; mode_sel = 0; t_width = 0; duty = 0; f_base = 0;
    sys_rst_n = 1'b1;
    model_reset();
    #2 sys_rst_n = 1'b0;
    #1 check_outputs(0, 0, 0, 0, 0);
    cycle(); cycle();
    @(negedge sys_clk) sys_rst_n = 1'b1;
    run(3);

    load(4'b0001, 1, 3, 1);   run(700);    // CW
    load(4'b0010, 1, 3, 37);  run(700);    // fixed pulse
    load(4'b0100, 1, 2, 1);   run(1800);   // stepped frequency
    load(4'b1000, 1, 2, 1);   run(1800);   // hop order
    load(4'b0010, 1, 0, 5);   run(20);     // duty = 0
    load(4'b0011, 1, 3, 5);   run(20);     // not one-hot
    load(4'b0010, 2, 3, 9);   run(20);     // t_width = 0 case follows
    load(4'b0100, 0, 2, 9);   run(20);
    load(4'b0010, 1, 2, 3);   run(350);    // recovery after error
    load(4'b0100, 2, 2, 7);   run(250);
    load(4'b1000, 1, 2, 11);  run(50);     // abort mid-pulse
    load(4'b0100, 1, 1, 13);  run(400);    // duty = 1 step mode
    load(4'b0010, 1, 3, 21);  run(50);

    @(negedge sys_clk) sys_rst_n = 1'b0;
    #1 model_reset();
    check_outputs(0, 0, 0, 0, 0);
    cycle(); cycle();
    @(negedge sys_clk) sys_rst_n = 1'b1;
    run(10);

    for (int i = 0; i < 15; i++) begin
      sel = $urandom_range(0, 5);
      rm  = (sel < 4) ? 4'(1 << sel) : 4'($urandom);
      load(rm, $urandom_range(1, 2), $urandom_range(0, 4), $urandom_range(0, 511));
      run($urandom_range(100, 1500));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
